// File: rtl/sram_arbiter.sv
// Time-slotted owner of one async 8-bit SRAM: slot 0 serves the CPU, slots 1..CH serve video reads.
// Each slot has three ce phases (ack/valid one clock after the P2 ce). There is no backpressure: the schedule is fixed and CPU requests wait.
module sram_arbiter #(
    parameter int AW     = 21,
    parameter int CH     = 3,
    parameter int GREEDY = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ce,
    input  logic            cpuReq,
    input  logic            cpuWr,
    input  logic [AW-1:0]   cpuA,
    input  logic [7:0]      cpuD,
    output logic [7:0]      cpuQ,
    output logic            cpuAck,
    input  logic [CH-1:0]   vidReq,
    input  logic [CH*AW-1:0] vidA,
    output logic [CH*8-1:0] vidQ,
    output logic [CH-1:0]   vidVld,
    output logic            ramWe,
    output logic [AW-1:0]   ramA,
    output logic [7:0]      ramDo,
    output logic            ramDoe,
    input  logic [7:0]      ramDi
);
    localparam int SW = $clog2(CH + 1);

    typedef enum logic [1:0] {P0, P1, P2} phase_t;

    phase_t         phase;
    logic [SW-1:0]  slot;
    logic [SW-1:0]  own_slot;
    logic           own_act;
    logic           own_cpu;
    logic           req_q;
    logic           pending;
    logic           cpu_wr;
    logic [AW-1:0]  cpu_a;
    logic [7:0]     cpu_d;
    logic           vid_hit;
    logic [AW-1:0]  vid_addr;

    always_comb begin
        vid_hit  = 1'b0;
        vid_addr = '0;
        for (int k = 0; k < CH; k++) begin
            if (slot == SW'(k + 1)) begin
                vid_hit  = vidReq[k];
                vid_addr = vidA[k*AW +: AW];
            end
        end
    end

    always_ff @(posedge clock) begin
        // Edge detector keeps tracking through reset so a request held high across reset is not re-issued.
        req_q <= cpuReq;
        if (reset) begin
            phase    <= P0;
            slot     <= '0;
            own_slot <= '0;
            own_act  <= 1'b0;
            own_cpu  <= 1'b0;
            pending  <= 1'b0;
            cpu_wr   <= 1'b0;
            cpu_a    <= '0;
            cpu_d    <= '0;
            ramWe    <= 1'b1;
            ramA     <= '0;
            ramDo    <= '0;
            ramDoe   <= 1'b0;
            cpuQ     <= '0;
            cpuAck   <= 1'b0;
            vidQ     <= '0;
            vidVld   <= '0;
        end else begin
            cpuAck <= 1'b0;
            vidVld <= '0;
            if (cpuReq && !req_q && !pending) begin
                pending <= 1'b1;
                cpu_wr  <= cpuWr;
                cpu_a   <= cpuA;
                cpu_d   <= cpuD;
            end
            if (ce) begin
                case (phase)
                    P0: begin
                        phase    <= P1;
                        own_slot <= slot;
                        own_act  <= 1'b0;
                        own_cpu  <= 1'b0;
                        ramDoe   <= 1'b0;
                        if (slot != '0 && vid_hit) begin
                            own_act <= 1'b1;
                            ramA    <= vid_addr;
                        end else if (pending && (slot == '0 || GREEDY != 0)) begin
                            own_act <= 1'b1;
                            own_cpu <= 1'b1;
                            ramA    <= cpu_a;
                            ramDo   <= cpu_d;
                            ramDoe  <= cpu_wr;
                        end
                    end
                    P1: begin
                        phase <= P2;
                        if (own_act && own_cpu && cpu_wr)
                            ramWe <= 1'b0;
                    end
                    P2: begin
                        phase   <= P0;
                        ramWe   <= 1'b1;
                        own_act <= 1'b0;
                        slot    <= (slot == SW'(CH)) ? '0 : slot + SW'(1);
                        if (own_act && own_cpu) begin
                            pending <= 1'b0;
                            cpuAck  <= 1'b1;
                            if (!cpu_wr)
                                cpuQ <= ramDi;
                        end else if (own_act) begin
                            for (int k = 0; k < CH; k++) begin
                                if (own_slot == SW'(k + 1)) begin
                                    vidVld[k]        <= 1'b1;
                                    vidQ[k*8 +: 8]   <= ramDi;
                                end
                            end
                        end
                    end
                    default: phase <= P0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: a GREEDY=0 and a GREEDY=1 arbiter share stimulus, each with its own SRAM model.
module tb_sram_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        cpuReq = 1'b0;
    logic        cpuWr = 1'b0;
    logic [20:0] cpuA = '0;
    logic [7:0]  cpuD = '0;
    logic [2:0]  vidReq = '0;
    logic [62:0] vidA = {21'h06000, 21'h04000, 21'h02000};

    logic [7:0]  cpuQ0, cpuQ1, ramDo0, ramDo1, ramDi0, ramDi1;
    logic        cpuAck0, cpuAck1, ramWe0, ramWe1, ramDoe0, ramDoe1;
    logic [23:0] vidQ0, vidQ1;
    logic [2:0]  vidVld0, vidVld1;
    logic [20:0] ramA0, ramA1;

    logic [7:0]  mem0 [0:4095];
    logic [7:0]  mem1 [0:4095];
    int          e_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          vid_res [3] = '{6, 9, 0};

    always #5 clock = ~clock;

    sram_arbiter #(.AW(21), .CH(3), .GREEDY(0)) dut0 (
        .clock(clock), .reset(reset), .ce(ce), .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuA(cpuA),
        .cpuD(cpuD), .cpuQ(cpuQ0), .cpuAck(cpuAck0), .vidReq(vidReq), .vidA(vidA), .vidQ(vidQ0),
        .vidVld(vidVld0), .ramWe(ramWe0), .ramA(ramA0), .ramDo(ramDo0), .ramDoe(ramDoe0), .ramDi(ramDi0)
    );

    sram_arbiter #(.AW(21), .CH(3), .GREEDY(1)) dut1 (
        .clock(clock), .reset(reset), .ce(ce), .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuA(cpuA),
        .cpuD(cpuD), .cpuQ(cpuQ1), .cpuAck(cpuAck1), .vidReq(vidReq), .vidA(vidA), .vidQ(vidQ1),
        .vidVld(vidVld1), .ramWe(ramWe1), .ramA(ramA1), .ramDo(ramDo1), .ramDoe(ramDoe1), .ramDi(ramDi1)
    );

    // Stored byte is XORed with the upper address bits so aliased locations read back distinct values.
    assign ramDi0 = mem0[ramA0[11:0]] ^ ramA0[20:13];
    assign ramDi1 = mem1[ramA1[11:0]] ^ ramA1[20:13];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = i[7:0];
            mem1[i] = i[7:0];
        end
    end

    always @(posedge clock) begin
        if (ramWe0 === 1'b0) mem0[ramA0[11:0]] <= ramDo0 ^ ramA0[20:13];
        if (ramWe1 === 1'b0) mem1[ramA1[11:0]] <= ramDo1 ^ ramA1[20:13];
        e_cnt <= reset ? 0 : e_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ce     = 1'b1;
        cpuReq = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Advance until the next clock edge has frame position m (ce held high).
    task automatic align(input int m);
        tick();
        for (int i = 0; i < 12 && (e_cnt % 12) != m; i++) tick();
    endtask

    task automatic cpu_run(input logic wr, input logic [20:0] a, input logic [7:0] d, input int n,
                           output int lat0, output int lat1, output int acks0, output int acks1,
                           output int we0, output logic [20:0] wa, output logic [7:0] wd,
                           output logic woe);
        lat0 = -1; lat1 = -1; acks0 = 0; acks1 = 0; we0 = 0;
        wa = '0; wd = '0; woe = 1'b0;
        cpuWr = wr; cpuA = a; cpuD = d; cpuReq = 1'b1;
        for (int j = 1; j <= n; j++) begin
            tick();
            if (cpuAck0) begin acks0++; if (lat0 < 0) lat0 = j; end
            if (cpuAck1) begin acks1++; if (lat1 < 0) lat1 = j; end
            if (!ramWe0) begin we0++; wa = ramA0; wd = ramDo0; woe = ramDoe0; end
        end
        cpuReq = 1'b0;
    endtask

    initial begin
        int lat0, lat1, acks0, acks1, we0, we1, cacks, cnt1, viol, vlat;
        int last [3];
        int cnt [3];
        logic [20:0] wa, pa;
        logic [7:0]  wd;
        logic        woe, pwe;

        // Reset state
        do_reset();
        check("rst_ramWe", ramWe0, 1);
        check("rst_ramDoe", ramDoe0, 0);
        check("rst_ramA", ramA0, 0);
        check("rst_ramDo", ramDo0, 0);
        check("rst_cpuQ", cpuQ0, 0);
        check("rst_cpuAck", cpuAck0, 0);
        check("rst_vidQ", vidQ0, 0);
        check("rst_vidVld", vidVld0, 0);
        check("rst_ramWe_g", ramWe1, 1);

        // CPU write captured just before slot 0 P0, request held high across ack
        align(11);
        cpu_run(1'b1, 21'h01234, 8'h5A, 30, lat0, lat1, acks0, acks1, we0, wa, wd, woe);
        check("wr_lat", lat0, 4);
        check("wr_lat_g", lat1, 4);
        check("wr_acks", acks0, 1);
        check("wr_acks_g", acks1, 1);
        check("wr_we_clocks", we0, 1);
        check("wr_addr", wa, 21'h01234);
        check("wr_data", wd, 8'h5A);
        check("wr_doe", woe, 1);

        // Read back
        align(11);
        cpu_run(1'b0, 21'h01234, 8'h00, 30, lat0, lat1, acks0, acks1, we0, wa, wd, woe);
        check("rd_lat", lat0, 4);
        check("rd_q", cpuQ0, 8'h5A);
        check("rd_q_g", cpuQ1, 8'h5A);
        check("rd_we_clocks", we0, 0);

        // Greedy steal: edge lands on slot 0 P0, slot 1 idle
        vidReq = 3'b010;
        align(0);
        cpu_run(1'b0, 21'h00010, 8'h00, 24, lat0, lat1, acks0, acks1, we0, wa, wd, woe);
        check("steal_lat_g", lat1, 6);
        check("steal_lat", lat0, 15);
        check("steal_q_g", cpuQ1, 8'h10);
        check("steal_q", cpuQ0, 8'h10);
        vidReq = 3'b000;

        // Fixed video schedule under continuous CPU traffic
        align(0);
        vidReq = 3'b111;
        cacks = 0; cnt1 = 0;
        for (int k = 0; k < 3; k++) begin last[k] = 0; cnt[k] = 0; end
        for (int j = 1; j <= 48; j++) begin
            cpuReq = (((j - 1) / 2) % 2) == 1;
            cpuWr  = 1'b0;
            cpuA   = 21'h00010;
            tick();
            if (cpuAck0) cacks++;
            if (vidVld1[0]) cnt1++;
            for (int k = 0; k < 3; k++) begin
                if (vidVld0[k]) begin
                    if (cnt[k] == 0) check("vid_slot", e_cnt % 12, vid_res[k]);
                    else check("vid_period", j - last[k], 12);
                    check("vid_data", vidQ0[k*8 +: 8], k + 1);
                    last[k] = j;
                    cnt[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++) check("vid_count", cnt[k], 4);
        check("vid_count_g", cnt1, 4);
        check("vid_cpu_acks", cacks, 3);
        cpuReq = 1'b0;
        vidReq = 3'b000;
        repeat (30) tick();

        // Second edge while pending is ignored
        align(0);
        cpuWr = 1'b0; cpuA = 21'h00020; cpuD = 8'h00; cpuReq = 1'b1;
        acks0 = 0; acks1 = 0; we0 = 0; we1 = 0;
        for (int j = 1; j <= 30; j++) begin
            if (j == 3) cpuReq = 1'b0;
            if (j == 5) begin cpuReq = 1'b1; cpuWr = 1'b1; cpuA = 21'h00030; cpuD = 8'hEE; end
            tick();
            if (cpuAck0) acks0++;
            if (cpuAck1) acks1++;
            if (!ramWe0) we0++;
            if (!ramWe1) we1++;
        end
        cpuReq = 1'b0; cpuWr = 1'b0;
        check("dup_acks", acks0, 1);
        check("dup_acks_g", acks1, 1);
        check("dup_q", cpuQ0, 8'h20);
        check("dup_q_g", cpuQ1, 8'h20);
        check("dup_we", we0, 0);
        check("dup_we_g", we1, 0);

        // Reset during the write's P1 aborts it
        align(11);
        cpuWr = 1'b1; cpuA = 21'h00040; cpuD = 8'h77; cpuReq = 1'b1;
        tick();
        tick();
        check("abort_doe_pre", ramDoe0, 1);
        cpuReq = 1'b0;
        reset = 1'b1;
        tick();
        check("abort_we", ramWe0, 1);
        check("abort_doe", ramDoe0, 0);
        check("abort_we_g", ramWe1, 1);
        tick();
        reset = 1'b0;
        cpuWr = 1'b0;
        acks0 = 0; acks1 = 0; we0 = 0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (cpuAck0) acks0++;
            if (cpuAck1) acks1++;
            if (!ramWe0 || !ramWe1) we0++;
        end
        check("abort_acks", acks0, 0);
        check("abort_acks_g", acks1, 0);
        check("abort_no_we", we0, 0);

        // ce one clock in four
        do_reset();
        vidReq = 3'b001;
        cpuWr = 1'b0; cpuA = 21'h01234; cpuReq = 1'b1;
        lat0 = -1; lat1 = -1; vlat = -1; acks0 = 0; viol = 0;
        pa = ramA0; pwe = ramWe0;
        for (int j = 1; j <= 40; j++) begin
            ce = (j % 4) == 2;
            tick();
            if (!ce && (ramA0 !== pa || ramWe0 !== pwe || cpuAck0 || vidVld0 != 3'b000)) viol++;
            pa = ramA0; pwe = ramWe0;
            if (cpuAck0) begin acks0++; if (lat0 < 0) lat0 = j; end
            if (cpuAck1 && lat1 < 0) lat1 = j;
            if (vidVld0[0] && vlat < 0) vlat = j;
        end
        ce = 1'b1;
        cpuReq = 1'b0;
        vidReq = 3'b000;
        check("ce_cpu_lat", lat0, 10);
        check("ce_cpu_lat_g", lat1, 10);
        check("ce_cpu_acks", acks0, 1);
        check("ce_cpu_q", cpuQ0, 8'h5A);
        check("ce_vid_lat", vlat, 22);
        check("ce_vid_q", vidQ0[7:0], 8'h01);
        check("ce_stable", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
